// File: rtl/uart_pkg.sv
// Shared definitions for the UART register-write command path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        CHK  = 2'd3
    } parse_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         FRAME_LEN         = 4;

    // Frame checksum: the sync marker is folded in so an all-zero frame is never valid.
    function automatic logic [7:0] cmd_checksum(
        input logic [7:0] addr,
        input logic [7:0] data,
        input logic [7:0] sync = SYNC_BYTE_DEFAULT
    );
        return addr ^ data ^ sync;
    endfunction

endpackage

// File: rtl/uart_byte_strobe.sv
// Turns the level-style valid from uart_rx into a one-cycle byte strobe.
module uart_byte_strobe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_data_valid,
    output logic       byte_stb,
    output logic [7:0] byte_data
);

    logic valid_q;

    // Delayed copy of valid; resets high so a level already present at release is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= 1'b1;
        else        valid_q <= rx_data_valid;
    end

    assign byte_stb  = rx_data_valid & ~valid_q;
    assign byte_data = rx_data;

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames received bytes into 4-byte write commands (sync, addr, data, checksum).
//
//   state | meaning
//   IDLE  | waiting for the sync byte; other bytes are dropped
//   ADDR  | next byte is the register address
//   DATA  | next byte is the register data
//   CHK   | next byte is the checksum; frame completes here
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter int         CLK_FREQ_HZ   = 12000000,
    parameter int         BAUD_RATE     = 9600,
    parameter int         TIMEOUT_BYTES = 4,
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_data_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       wr_en,
    output logic       err_checksum,
    output logic       err_timeout,
    output logic       busy
);

    localparam int               TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * (CLK_FREQ_HZ / BAUD_RATE);
    localparam int               CNT_W          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_TC     = CNT_W'(TIMEOUT_CYCLES);

    parse_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       addr_r, data_r;
    logic             byte_stb;
    logic [7:0]       byte_data;
    logic             timeout_hit;
    logic             frame_done, chk_ok;
    logic             wr_en_d, err_checksum_d, err_timeout_d;

    uart_byte_strobe u_byte_strobe (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .byte_stb      (byte_stb),
        .byte_data     (byte_data)
    );

    // An accepted byte always beats a timeout landing in the same cycle.
    assign timeout_hit = (state_q != IDLE) && (cnt_q == TIMEOUT_TC) && !byte_stb;

    // State register and inter-byte timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (byte_stb || timeout_hit || state_q == IDLE) cnt_q <= '0;
            else                                            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Next-state logic: one step per accepted byte, timeout drops back to IDLE.
    always_comb begin
        state_d = state_q;
        if (byte_stb) begin
            case (state_q)
                IDLE: if (byte_data == SYNC_BYTE) state_d = ADDR;
                ADDR: state_d = DATA;
                DATA: state_d = CHK;
                CHK:  state_d = IDLE;
            endcase
        end else if (timeout_hit) begin
            state_d = IDLE;
        end
    end

    // Output decode: frame completion result and timeout pulse, registered below.
    always_comb begin
        frame_done     = byte_stb && (state_q == CHK);
        chk_ok         = (byte_data == cmd_checksum(addr_r, data_r, SYNC_BYTE));
        wr_en_d        = frame_done && chk_ok;
        err_checksum_d = frame_done && !chk_ok;
        err_timeout_d  = timeout_hit;
    end

    // Field latches and registered outputs; wr_addr/wr_data only move on a good frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r       <= '0;
            data_r       <= '0;
            wr_addr      <= '0;
            wr_data      <= '0;
            wr_en        <= 1'b0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (byte_stb && state_q == ADDR) addr_r <= byte_data;
            if (byte_stb && state_q == DATA) data_r <= byte_data;
            if (wr_en_d) begin
                wr_addr <= addr_r;
                wr_data <= data_r;
            end
            wr_en        <= wr_en_d;
            err_checksum <= err_checksum_d;
            err_timeout  <= err_timeout_d;
            busy         <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed frames plus random traffic against a frame-level model.
module tb_uart_cmd_parser;
    import uart_pkg::*;

    localparam int CLK_FREQ_HZ    = 1000;
    localparam int BAUD_RATE      = 100;
    localparam int TIMEOUT_BYTES  = 4;
    localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * (CLK_FREQ_HZ / BAUD_RATE);

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_data_valid = 1'b0;
    logic [7:0] wr_addr, wr_data;
    logic       wr_en, err_checksum, err_timeout, busy;

    uart_cmd_parser #(
        .CLK_FREQ_HZ   (CLK_FREQ_HZ),
        .BAUD_RATE     (BAUD_RATE),
        .TIMEOUT_BYTES (TIMEOUT_BYTES),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
        .err_checksum  (err_checksum),
        .err_timeout   (err_timeout),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    int         cyc = 0;
    int         bytes_sent = 0;
    int         bytes_seen = 0;
    int         last_evt = 0;
    logic [7:0] frame[$];
    logic [7:0] m_addr = 8'h00, m_data = 8'h00;
    logic       m_wr_en = 1'b0, m_cerr = 1'b0, m_terr = 1'b0, m_busy = 1'b0;

    always @(posedge clk) begin
        cyc++;
        m_wr_en = 1'b0;
        m_cerr  = 1'b0;
        m_terr  = 1'b0;
        if (!rst_n) begin
            frame.delete();
            m_addr = 8'h00;
            m_data = 8'h00;
            bytes_seen = bytes_sent;
        end else if (bytes_seen != bytes_sent) begin
            bytes_seen = bytes_sent;
            last_evt   = cyc;
            if (frame.size() == 0) begin
                if (rx_data == 8'hA5) frame.push_back(rx_data);
            end else begin
                frame.push_back(rx_data);
                if (frame.size() == FRAME_LEN) begin
                    if (frame[3] == cmd_checksum(frame[1], frame[2])) begin
                        m_wr_en = 1'b1;
                        m_addr  = frame[1];
                        m_data  = frame[2];
                    end else begin
                        m_cerr = 1'b1;
                    end
                    frame.delete();
                end
            end
        end else if (frame.size() != 0 && (cyc - last_evt) == TIMEOUT_CYCLES + 1) begin
            m_terr = 1'b1;
            frame.delete();
        end
        m_busy = (frame.size() != 0);
    end

    // ---------------- per-cycle compare and pulse monitor ----------------
    int wr_cnt = 0, cerr_cnt = 0, terr_cnt = 0, terr_edge = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_wr_addr", wr_addr, 0);
            chk("rst_wr_data", wr_data, 0);
            chk("rst_wr_en", wr_en, 0);
            chk("rst_err_checksum", err_checksum, 0);
            chk("rst_err_timeout", err_timeout, 0);
            chk("rst_busy", busy, 0);
        end else begin
            chk("wr_addr", wr_addr, m_addr);
            chk("wr_data", wr_data, m_data);
            chk("wr_en", wr_en, m_wr_en);
            chk("err_checksum", err_checksum, m_cerr);
            chk("err_timeout", err_timeout, m_terr);
            chk("busy", busy, m_busy);
            chk("pulse_exclusive",
                (int'(wr_en) + int'(err_checksum) + int'(err_timeout)) <= 1, 1);
            if (wr_en)        wr_cnt++;
            if (err_checksum) cerr_cnt++;
            if (err_timeout) begin
                terr_cnt++;
                terr_edge = cyc;
            end
        end
    end

    // ---------------- driver ----------------
    int last_acc = 0;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Call right after a tick; the byte is accepted at the next rising edge.
    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        rx_data       = b;
        rx_data_valid = 1'b1;
        bytes_sent++;
        last_acc = cyc + 1;
        repeat (hold) tick();
        rx_data_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send_byte(8'hA5, 1, 3);
        send_byte(a, 1, 3);
        send_byte(d, 1, 3);
        send_byte(c, 1, 3);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual=expired required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         wr0, l0, kind, nb;
        logic [7:0] a, d, c;

        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("reset_busy", busy, 0);
        chk("reset_wr_addr", wr_addr, 0);
        chk("checksum_rule", cmd_checksum(8'h12, 8'h34), 8'h83);

        // valid frame
        send_frame(8'h12, 8'h34, 8'h83);
        chk("valid_wr_addr", wr_addr, 8'h12);
        chk("valid_wr_data", wr_data, 8'h34);
        chk("valid_wr_count", wr_cnt, 1);
        chk("valid_no_cerr", cerr_cnt, 0);

        // bad checksum
        send_frame(8'h12, 8'h34, 8'h00);
        chk("badcs_cerr_count", cerr_cnt, 1);
        chk("badcs_wr_count", wr_cnt, 1);
        chk("badcs_hold_addr", wr_addr, 8'h12);
        chk("badcs_hold_data", wr_data, 8'h34);
        chk("badcs_busy", busy, 0);

        // leading garbage
        send_byte(8'h00, 2, 3);
        send_byte(8'hFF, 1, 4);
        send_frame(8'h01, 8'h02, 8'hA6);
        chk("garbage_wr_count", wr_cnt, 2);
        chk("garbage_wr_addr", wr_addr, 8'h01);
        chk("garbage_wr_data", wr_data, 8'h02);

        // truncated frame times out 401 edges after the last accept
        send_byte(8'hA5, 1, 3);
        send_byte(8'h12, 1, 3);
        l0 = last_acc;
        while (cyc < l0 + TIMEOUT_CYCLES + 5) tick();
        chk("timeout_count", terr_cnt, 1);
        chk("timeout_edge", terr_edge, l0 + 401);
        chk("timeout_busy", busy, 0);
        send_frame(8'h01, 8'h02, 8'hA6);
        chk("after_timeout_wr_count", wr_cnt, 3);

        // byte lands exactly when the counter reaches the limit
        send_byte(8'hA5, 1, 3);
        send_byte(8'h12, 1, 3);
        l0 = last_acc;
        while (cyc < l0 + TIMEOUT_CYCLES) tick();
        send_byte(8'h34, 1, 3);
        chk("edge_accept_cycle", last_acc, l0 + 401);
        send_byte(8'h83, 1, 3);
        chk("edge_no_timeout", terr_cnt, 1);
        chk("edge_wr_count", wr_cnt, 4);
        chk("edge_wr_addr", wr_addr, 8'h12);

        // reset mid-frame with valid held high through release
        send_byte(8'hA5, 1, 3);
        send_byte(8'h12, 1, 3);
        rst_n         = 1'b0;
        rx_data       = 8'hA5;
        rx_data_valid = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_wr_addr", wr_addr, 0);
        chk("midrst_wr_data", wr_data, 0);
        rx_data_valid = 1'b0;
        repeat (3) tick();
        wr0 = wr_cnt;
        send_frame(8'h07, 8'h08, cmd_checksum(8'h07, 8'h08));
        chk("midrst_frame_writes", wr_cnt - wr0, 1);
        chk("midrst_frame_addr", wr_addr, 8'h07);

        // randomized traffic
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 4);
            a = 8'($urandom);
            d = 8'($urandom);
            c = cmd_checksum(a, d);
            case (kind)
                0: c = c;
                1: c = c ^ 8'($urandom_range(1, 255));
                2: begin
                    nb = $urandom_range(1, 3);
                    for (int j = 0; j < nb; j++)
                        send_byte(8'($urandom), $urandom_range(1, 3), $urandom_range(3, 8));
                end
                3: begin
                    nb = $urandom_range(1, 3);
                    send_byte(8'hA5, $urandom_range(1, 3), $urandom_range(3, 8));
                    if (nb > 1) send_byte(a, $urandom_range(1, 3), $urandom_range(3, 8));
                    if (nb > 2) send_byte(d, $urandom_range(1, 3), $urandom_range(3, 8));
                    repeat (TIMEOUT_CYCLES + 10) tick();
                end
                default: c = c;
            endcase
            if (kind != 3) begin
                send_byte(8'hA5, $urandom_range(1, 3), $urandom_range(3, 8));
                send_byte(a, $urandom_range(1, 3), $urandom_range(3, 8));
                send_byte(d, $urandom_range(1, 3), $urandom_range(3, 8));
                send_byte(c, $urandom_range(1, 3), $urandom_range(3, 8));
            end
        end
        repeat (TIMEOUT_CYCLES + 10) tick();
        chk("random_saw_writes", wr_cnt > 5, 1);
        chk("final_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
